// File: rtl/alu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter_if
// Request/response channels between the two ALU requesters and the
// arbiter. Port 0 carries the core datapath and port 1 the UART debug path.
//   reqN_valid/ready : request handshake (reqN_ready is combinational)
//   reqN_a/b/sel     : operands and ALU select for port N
//   rspN_valid/ready : response handshake for port N
//   rsp_data/zero    : shared result bus, qualified by rspN_valid
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
   parameter int unsigned LENGTH = 32
);
   localparam int unsigned SEL_W = 3;

   logic              req0_valid;
   logic              req0_ready;
   logic [LENGTH-1:0] req0_a;
   logic [LENGTH-1:0] req0_b;
   logic [SEL_W-1:0]  req0_sel;

   logic              req1_valid;
   logic              req1_ready;
   logic [LENGTH-1:0] req1_a;
   logic [LENGTH-1:0] req1_b;
   logic [SEL_W-1:0]  req1_sel;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [LENGTH-1:0] rsp_data;
   logic              rsp_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, rsp_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are registered onto the ALU inputs, the ALU
// result is captured one cycle later (EXEC) and returned on the owner's
// response channel, which is held until the owner takes it (RESP).
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   bus_if       : request/response channels for both ports (slave modport)
//   alu_a_o/b_o  : registered operands to the shared ALU
//   alu_sel_o    : registered ALU select code (forwarded unchanged)
//   alu_out_i    : ALU result (combinational from alu_a_o/alu_b_o/alu_sel_o)
//   alu_zero_i   : ALU zero flag
//   busy_o       : high whenever the arbiter is not in IDLE
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN : when defined, port 0 always wins simultaneous
//                           requests and no round-robin pointer exists.
//                           Default (undefined) is round-robin.
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int unsigned LENGTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_share_arbiter_if.slave  bus_if,
   output logic [LENGTH-1:0]   alu_a_o,
   output logic [LENGTH-1:0]   alu_b_o,
   output logic [2:0]          alu_sel_o,
   input  logic [LENGTH-1:0]   alu_out_i,
   input  logic                alu_zero_i,
   output logic                busy_o
);

   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic               owner_q,    owner_d;
   logic [LENGTH-1:0]  alu_a_q,    alu_a_d;
   logic [LENGTH-1:0]  alu_b_q,    alu_b_d;
   logic [SEL_W-1:0]   alu_sel_q,  alu_sel_d;
   logic [LENGTH-1:0]  rsp_data_q, rsp_data_d;
   logic               rsp_zero_q, rsp_zero_d;
   logic               rsp0_vld_q, rsp0_vld_d;
   logic               rsp1_vld_q, rsp1_vld_d;
   logic               busy_q,     busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic               prio_q,     prio_d;
`endif

   // Combinational grant/ready decode (valid only in IDLE)
   logic               grant_c;
   logic               req0_ready_c;
   logic               req1_ready_c;
   logic               owner_rsp_ready_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
         busy_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         prio_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
         rsp0_vld_q <= rsp0_vld_d;
         rsp1_vld_q <= rsp1_vld_d;
         busy_q     <= busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         prio_q     <= prio_d;
`endif
      end
   end

   // Next-state, grant and capture logic
   always_comb begin
      state_d           = state_q;
      owner_d           = owner_q;
      alu_a_d           = alu_a_q;
      alu_b_d           = alu_b_q;
      alu_sel_d         = alu_sel_q;
      rsp_data_d        = rsp_data_q;
      rsp_zero_d        = rsp_zero_q;
      rsp0_vld_d        = rsp0_vld_q;
      rsp1_vld_d        = rsp1_vld_q;
      grant_c           = 1'b0;
      req0_ready_c      = 1'b0;
      req1_ready_c      = 1'b0;
      owner_rsp_ready_c = owner_q ? bus_if.rsp1_ready : bus_if.rsp0_ready;
`ifndef ALU_ARB_FIXED_PRIO_EN
      prio_d            = prio_q;
`endif

      case (state_q)
         IDLE: begin
            // A lone requester wins outright; contention is settled by the
            // round-robin pointer (or fixed to port 0 in the fixed build).
            if (bus_if.req0_valid && bus_if.req1_valid) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
               grant_c = prio_q;
`else
               grant_c = 1'b0;
`endif
            end else begin
               grant_c = bus_if.req1_valid;
            end

            req0_ready_c = bus_if.req0_valid && !grant_c;
            req1_ready_c = bus_if.req1_valid &&  grant_c;

            if (req0_ready_c || req1_ready_c) begin
               alu_a_d   = grant_c ? bus_if.req1_a   : bus_if.req0_a;
               alu_b_d   = grant_c ? bus_if.req1_b   : bus_if.req0_b;
               alu_sel_d = grant_c ? bus_if.req1_sel : bus_if.req0_sel;
               owner_d   = grant_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
               prio_d    = !grant_c;
`endif
               state_d   = EXEC;
            end
         end

         EXEC: begin
            // ALU inputs have been stable for a full cycle; sample its output.
            rsp_data_d = alu_out_i;
            rsp_zero_d = alu_zero_i;
            rsp0_vld_d = !owner_q;
            rsp1_vld_d =  owner_q;
            state_d    = RESP;
         end

         RESP: begin
            if (owner_rsp_ready_c) begin
               rsp0_vld_d = 1'b0;
               rsp1_vld_d = 1'b0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus_if.req0_ready = req0_ready_c;
   assign bus_if.req1_ready = req1_ready_c;
   assign bus_if.rsp0_valid = rsp0_vld_q;
   assign bus_if.rsp1_valid = rsp1_vld_q;
   assign bus_if.rsp_data   = rsp_data_q;
   assign bus_if.rsp_zero   = rsp_zero_q;

   assign alu_a_o   = alu_a_q;
   assign alu_b_o   = alu_b_q;
   assign alu_sel_o = alu_sel_q;
   assign busy_o    = busy_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter that time-shares one combinational ALU instance between the core datapath (port 0) and the UART debug/command path (port 1). Each port issues an operation with a valid/ready handshake. The arbiter registers the operands and drives the shared ALU. It captures the result and zero flag and returns them on that port's response channel, which also uses valid/ready. It sits between the requesters and the ALU, with the ALU ports wired directly to it.

## Interface
- LENGTH, 32: operand/result width; matches the ALU LENGTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid, req1_valid  input  1  operation request per port.
- req0_ready, req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  input  LENGTH  operands.
- req0_sel, req1_sel  input  3  ALU_Sel code, passed through unmodified.
- rsp0_valid, rsp1_valid  output  1  result available.
- rsp0_ready, rsp1_ready  input  1  requester takes the result.
- rsp_data  output  LENGTH  result, shared by both ports; qualified by rspN_valid.
- rsp_zero  output  1  captured ALU zero flag.
- alu_a, alu_b  output  LENGTH  registered operands to the ALU.
- alu_sel  output  3  registered select to the ALU.
- alu_out  input  LENGTH  ALU result (combinational).
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Three-state FSM: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port named by the round-robin pointer `prio` (reset 0).
  - reqN_ready is combinational: high only in IDLE and only for the granted port.
  - On accept (valid & ready), latch a, b and sel into alu_a/alu_b/alu_sel, record `owner`, set `prio` to the other port, and go to EXEC.
- EXEC: lasts one cycle. Capture alu_out into rsp_data and alu_zero into rsp_zero, set rsp{owner}_valid, and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_zero stable until rsp{owner}_ready is high.
  - On that handshake cycle, clear rsp_valid and return to IDLE.
  - Requests are not accepted in the handshake cycle; the next accept is the following cycle at the earliest.
- The non-owner port's rsp_valid is always 0. Its rsp_ready is ignored.
- Requesters hold valid, a, b and sel stable until ready. The arbiter never samples an operand outside the accept cycle.
- Invalid sel codes are forwarded unchanged. The ALU returns 0, so rsp_zero=1.
- alu_a/alu_b/alu_sel hold their last values outside EXEC. Nothing else captures alu_out.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, prio=0, owner=0.
  - alu_a=alu_b=0, alu_sel=0.
  - rsp_data=0, rsp_zero=0, rsp0_valid=rsp1_valid=0, busy=0.
  - req ready signals evaluate to 0 unless a port is valid in IDLE.
- Latency: accept in cycle N gives rspN_valid high in cycle N+2, with ALU output sampled at the end of N+1.
- Minimum issue interval: 3 cycles per operation when rsp_ready is held high.
- Reset asserted in EXEC or RESP: the operation is dropped, no response is produced, and the requester must reissue.
- Simultaneous requests: both valid with prio=0 serves port 0 then port 1. If port 0 re-requests at once, port 1 still goes next because prio now points to 1.
- A lone requester is granted regardless of prio, and prio still flips on each accept.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: port 0 always wins simultaneous requests; `prio` is neither implemented nor updated.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then req0 ADD (sel 010) a=7, b=5, accepted in cycle N, rsp0_ready=1 -> rsp0_valid in N+2, rsp_data=12, rsp_zero=0, rsp1_valid=0.
- req1 SUB (sel 110) a=5, b=5 -> rsp1_valid, rsp_data=0, rsp_zero=1. Then req1 sel 101 a=6, b=7 -> rsp_data=42.
- Both ports valid from reset and continuously re-requesting -> grants alternate 0,1,0,1 every 3 cycles. With ALU_ARB_FIXED_PRIO_EN, port 0 is granted every time and port 1 never.
- rsp0_ready held low for 5 cycles after rsp0_valid -> rsp_data and rsp_zero stable, req ready signals 0, busy=1 throughout. Next accept happens the cycle after the handshake.
- rst_n pulsed low during EXEC -> all outputs 0 immediately, no rsp_valid after release. Next request behaves as the first after reset, with port 0 favoured.
- req0 with sel 111, a=1, b=32'h0000_0023 -> rsp_data=8 (shift uses b[4:0]=3). Then invalid-path check: sel forwarded, and alu_sel observed equal to the request's sel for exactly the EXEC cycle onward.
